req_arbiter_8: RTL and testbench

Upstream front end for the 8-to-3 encoder stage. Captures rising edges on eight request lines into sticky pending bits, picks one pending request with round-robin priority, and presents it as a stable one-hot vector `grant[7:0]`, which feeds the encoder's `i[7:0]` directly. A valid/ack handshake holds each grant until the consumer takes it. Because `grant` is always zero or exactly one-hot, the downstream OR-based encoder never sees a multi-hot input.

---
 rtl/req_arbiter_8.sv | 70 +++++++
 tb/tb_req_arbiter_8.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/req_arbiter_8.sv
// req_arbiter_8: edge-captured sticky requests, round-robin pick, one-hot grant held under valid/ack.
module req_arbiter_8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       ack,
    input  logic       clr_ovf,
    output logic [7:0] grant,
    output logic       valid,
    output logic [7:0] pending,
    output logic       ovf
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t     state_q, state_d;
    logic [7:0] req_q, pending_q, pending_d, grant_q, grant_d, rise, clr_mask;
    logic       ovf_q, ovf_d;
    logic [2:0] ptr_q, ptr_d, gidx_q, gidx_d, win_idx, cand;
    // Scan from the farthest offset down so the nearest pending bit at/after ptr wins.
    always_comb begin
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr_q + 3'(k);
            if (pending_q[cand]) win_idx = cand;
        end
    end
    always_comb begin
        rise      = req & ~req_q;
        clr_mask  = (state_q == GRANT && ack) ? grant_q : 8'h00;
        pending_d = (pending_q & ~clr_mask) | rise;
        ovf_d     = (|(rise & pending_q & ~clr_mask)) | (ovf_q & ~clr_ovf);
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        if (state_q == IDLE) begin
            if (|pending_q) begin
                grant_d = 8'h01 << win_idx;
                gidx_d  = win_idx;
                state_d = GRANT;
            end
        end else if (ack) begin
            grant_d = 8'h00;
            ptr_d   = gidx_q + 3'd1;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        req_q <= req;
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 8'h00;
            grant_q   <= 8'h00;
            ovf_q     <= 1'b0;
            ptr_q     <= 3'd0;
            gidx_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
        end
    end
    assign grant   = grant_q;
    assign valid   = (state_q == GRANT);
    assign pending = pending_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_req_arbiter_8.sv
// tb_req_arbiter_8: directed scenarios plus randomized run against a behavioural model.
module tb_req_arbiter_8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       ack = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] grant, pending;
    logic       valid, ovf;
    int n_pass = 0;
    int n_total = 0;
    bit [7:0] m_pend, m_reqp;
    bit       m_valid, m_ovf;
    int       m_gidx, m_ptr;

    req_arbiter_8 dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .clr_ovf(clr_ovf),
        .grant(grant), .valid(valid), .pending(pending), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Advance the reference model by one clock using the current inputs, then clock the DUT.
    task automatic tick();
        bit [7:0] newp;
        bit lost;
        bit cleared;
        int idx;
        bit found;
        if (!rst_n) begin
            m_pend = 0; m_valid = 0; m_ovf = 0; m_ptr = 0; m_gidx = 0;
        end else begin
            lost = 0;
            for (int i = 0; i < 8; i++) begin
                cleared = m_valid && ack && (i == m_gidx);
                if (req[i] && !m_reqp[i] && m_pend[i] && !cleared) lost = 1;
                newp[i] = (m_pend[i] && !cleared) || (req[i] && !m_reqp[i]);
            end
            m_ovf = lost || (m_ovf && !clr_ovf);
            if (m_valid) begin
                if (ack) begin
                    m_ptr = (m_gidx + 1) % 8;
                    m_valid = 0;
                end
            end else begin
                found = 0;
                for (int off = 0; off < 8; off++) begin
                    idx = (m_ptr + off) % 8;
                    if (!found && m_pend[idx]) begin
                        found = 1;
                        m_gidx = idx;
                    end
                end
                m_valid = found;
            end
            m_pend = newp;
        end
        m_reqp = req;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = 8'h00; ack = 0; clr_ovf = 0; rst_n = 0;
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        req = 8'h81; rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick(); tick();
        n_total++;
        if ({pending, grant, valid, ovf} !== 18'h0)
            $display("FAIL reset_hold: pending=%h grant=%h valid=%b ovf=%b, need all 0", pending, grant, valid, ovf);
        else n_pass++;
        req = 8'h89;
        tick();
        n_total++;
        if (pending !== 8'h08 || valid !== 1'b0)
            $display("FAIL reset_first_pending: pending=%h valid=%b, need 08/0", pending, valid);
        else n_pass++;
        tick();
        n_total++;
        if (grant !== 8'h08 || valid !== 1'b1)
            $display("FAIL reset_first_grant: grant=%h valid=%b, need 08/1", grant, valid);
        else n_pass++;
        ack = 1;
        tick();
        ack = 0;
        n_total++;
        if (valid !== 1'b0 || pending !== 8'h00)
            $display("FAIL reset_first_ack: valid=%b pending=%h, need 0/00", valid, pending);
        else n_pass++;
    endtask

    task automatic test_ack_high();
        logic [7:0] exp_g [0:6] = '{8'h00, 8'h04, 8'h00, 8'h20, 8'h00, 8'h80, 8'h00};
        do_reset();
        req = 8'hA4; ack = 1;
        for (int c = 0; c < 7; c++) begin
            tick();
            n_total++;
            if (grant !== exp_g[c] || valid !== (exp_g[c] != 8'h00))
                $display("FAIL ack_high_seq%0d: grant=%h valid=%b, need %h", c, grant, valid, exp_g[c]);
            else n_pass++;
        end
        req = 8'h00;
        tick();
        req = 8'h81;
        tick(); tick();
        n_total++;
        if (grant !== 8'h01)
            $display("FAIL ack_high_wrap_ptr: grant=%h, need 01", grant);
        else n_pass++;
        tick(); tick();
        n_total++;
        if (grant !== 8'h80)
            $display("FAIL ack_high_wrap_next: grant=%h, need 80", grant);
        else n_pass++;
        ack = 0; req = 8'h00;
        tick(); tick();
    endtask

    task automatic test_rotation();
        do_reset();
        req = 8'h20; ack = 1;
        tick(); tick(); tick();
        ack = 0; req = 8'h00;
        tick();
        req = 8'h44;
        tick(); tick();
        n_total++;
        if (grant !== 8'h40)
            $display("FAIL rotation_first: grant=%h, need 40", grant);
        else n_pass++;
        ack = 1;
        tick();
        ack = 0;
        tick();
        n_total++;
        if (grant !== 8'h04)
            $display("FAIL rotation_second: grant=%h, need 04", grant);
        else n_pass++;
        ack = 1; tick(); ack = 0; req = 8'h00; tick();
    endtask

    task automatic test_stall();
        int bad = 0;
        do_reset();
        req = 8'h10;
        tick(); tick();
        for (int c = 0; c < 10; c++) begin
            if (c == 3) req = 8'h12;
            tick();
            if (grant !== 8'h10 || valid !== 1'b1) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL stall_hold: grant=%h valid=%b, %0d unstable cycles, need 10/1", grant, valid, bad);
        else n_pass++;
        n_total++;
        if (pending !== 8'h12) $display("FAIL stall_pending: pending=%h, need 12", pending);
        else n_pass++;
        ack = 1; tick(); ack = 0; tick();
        n_total++;
        if (grant !== 8'h02) $display("FAIL stall_next: grant=%h, need 02", grant);
        else n_pass++;
        ack = 1; tick(); ack = 0; req = 8'h00; tick();
    endtask

    task automatic test_overflow();
        do_reset();
        req = 8'h04; tick(); tick();
        req = 8'h00; tick();
        req = 8'h04; tick();
        n_total++;
        if (ovf !== 1'b1) $display("FAIL ovf_set: ovf=%b, need 1", ovf);
        else n_pass++;
        req = 8'h00; tick();
        req = 8'h04; ack = 1; tick();
        ack = 0;
        n_total++;
        if (pending[2] !== 1'b1 || ovf !== 1'b1 || valid !== 1'b0)
            $display("FAIL ovf_rearm: pending=%h ovf=%b valid=%b, need bit2=1 ovf=1 valid=0", pending, ovf, valid);
        else n_pass++;
        clr_ovf = 1; tick(); clr_ovf = 0;
        n_total++;
        if (ovf !== 1'b0 || grant !== 8'h04)
            $display("FAIL ovf_clear: ovf=%b grant=%h, need 0/04", ovf, grant);
        else n_pass++;
        req = 8'h00; tick();
        req = 8'h04; clr_ovf = 1; tick(); clr_ovf = 0;
        n_total++;
        if (ovf !== 1'b1) $display("FAIL ovf_set_wins: ovf=%b, need 1", ovf);
        else n_pass++;
        ack = 1; tick(); tick(); tick(); ack = 0; req = 8'h00; tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 8'h30; tick(); tick();
        rst_n = 0; tick(); rst_n = 1;
        n_total++;
        if ({pending, grant, valid, ovf} !== 18'h0)
            $display("FAIL reset_mid: pending=%h grant=%h valid=%b ovf=%b, need all 0", pending, grant, valid, ovf);
        else n_pass++;
        tick();
        n_total++;
        if ({pending, grant, valid} !== 17'h0)
            $display("FAIL reset_mid_after: pending=%h grant=%h valid=%b, need all 0", pending, grant, valid);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        int shape = 0;
        logic [7:0] eg;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req = 8'($urandom);
            ack = ($urandom_range(0, 2) != 0);
            clr_ovf = ($urandom_range(0, 7) == 0);
            tick();
            eg = m_valid ? (8'h01 << m_gidx) : 8'h00;
            if (grant !== eg || valid !== m_valid || pending !== m_pend || ovf !== m_ovf) begin
                if (errs < 5)
                    $display("FAIL random_c%0d: grant=%h valid=%b pending=%h ovf=%b, need %h/%b/%h/%b",
                             c, grant, valid, pending, ovf, eg, m_valid, m_pend, m_ovf);
                errs++;
            end
            if ((grant & (grant - 8'h01)) !== 8'h00 || (valid !== (grant != 8'h00))) shape++;
        end
        n_total++;
        if (errs != 0) $display("FAIL random_model: %0d cycles differ, need 0", errs);
        else n_pass++;
        n_total++;
        if (shape != 0) $display("FAIL random_onehot: %0d bad grant shapes, need 0", shape);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ack_high();
        test_rotation();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
